addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised multi-cycle adder/subtractor for the simple processor datapath. Processes a WIDTH-bit operation CHUNK bits per cycle through one ripple-carry chunk, trading latency for area. Provides a start/done handshake and a full flag set: carry, signed overflow at any width, zero and negative. Sits between the register file read ports and the ALU result mux.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK cycles per operation
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- sub  in  1  0 = add, 1 = subtract
- a, b  in  WIDTH  operands, sampled on accept
- cin  in  1  carry-in (add) / borrow-in (sub, active-high), sampled on accept
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when result/flags update
- result  out  WIDTH  sum/difference, held until next done
- cout  out  1  carry-out (add); NOT borrow (sub)
- overflow  out  1  signed overflow
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]

## Operation
- Add: result = a + b + cin. Sub: result = a + ~b + !cin, i.e. a - b - cin.
- FSM states IDLE, RUN, DONE.
- IDLE: ready=1. start=1 latches a, b (b inverted if sub), effective carry, clears chunk counter, goes to RUN.
- RUN: each cycle adds the low CHUNK bits of the operand shift registers with the running carry; sum chunk shifts into result from the top, operands shift right by CHUNK. Counter increments; after chunk NCHUNK-1 goes to DONE.
- Last chunk also records carry into bit WIDTH-1; overflow = carry into MSB XOR carry out of MSB. Valid for any WIDTH.
- DONE: result, cout, overflow, zero, negative update; done=1; returns to IDLE next cycle.
- start while ready=0 is ignored and not queued.
- Flags zero/negative are computed on the final (post-saturation) result.
- Outputs are not updated during RUN; result shown is the previous operation's until done.

## Timing
- Accept at edge t (start=1, ready=1) -> done=1 during cycle t+NCHUNK+1; ready low from t+1 through done cycle, high the cycle after.
- CHUNK=WIDTH: single RUN cycle, done two cycles after accept.
- Back-to-back: next accept possible the cycle after done; throughput one op per NCHUNK+2 cycles.
- Reset: state IDLE, ready=1, done=0, result=0, all flags 0, counter 0; takes effect at next edge, including mid-RUN (operation discarded, no done).
- reset and start same cycle: reset wins.

## Configuration
- ADDSUB_SAT_EN defined: on signed overflow, result saturates to 0x7F..F (positive overflow) or 0x80..0 (negative overflow); overflow still reported 1; cout unchanged.
- Undefined: result wraps modulo 2^WIDTH.

## Structure
- Shared package: state encoding (IDLE, RUN, DONE) and add/sub mode constants, reused by the processor control unit.
- One sub-module: addsub_chunk, CHUNK-bit combinational ripple adder with outputs sum, cout and carry into its top bit.
- Counter width $clog2(NCHUNK), minimum 1.

## Test plan
- WIDTH=16, CHUNK=4, add 0x1234+0x0FFF, cin=0 -> 0x2233, cout=0, overflow=0, done exactly 5 cycles after accept.
- Add 0x7FFF+0x0001 -> 0x8000, overflow=1, negative=1; with ADDSUB_SAT_EN -> 0x7FFF, negative=0.
- Sub 0x0005-0x0005, cin=0 -> 0x0000, zero=1, cout=1, overflow=0.
- Sub 0x0000-0x0001 -> 0xFFFF, cout=0, negative=1, overflow=0; sub 0x8000-0x0001 -> 0x7FFF, overflow=1 (SAT: 0x8000).
- start pulsed during RUN with other operands -> ignored, first result unaffected; reset asserted 2 cycles into RUN -> next cycle ready=1, result=0, no done pulse.
- CHUNK=16 build, add 0xFFFF+0x0000, cin=1 -> 0x0000, cout=1, zero=1, done 2 cycles after accept.

Source files
------------

// File: rtl/addsub_serial_pkg.sv
// addsub_serial shared types: FSM state encoding and add/sub mode constants.
// Also used by the processor control unit.
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial request/result bundle.
// master drives operands and start, slave returns result and flags.
interface addsub_serial_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, sub, a, b, cin,
    input  ready, done, result, cout,
    input  overflow, zero, negative
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, done, result, cout,
    output overflow, zero, negative
  );

endinterface

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple adder slice.
// Also exposes the carry into its top bit for overflow detection.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i}
                + {{CHUNK{1'b0}}, c_i};
  assign sum_o  = full[CHUNK-1:0];
  assign cout_o = full[CHUNK];
  assign cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1]
                ^ full[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/sub, CHUNK bits per cycle, start/done handshake.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            reset,
  addsub_serial_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW =
    (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [CHUNK-1:0] sum;
  logic             co;
  logic             cm;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;
  logic [WIDTH-1:0] fin_d;

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i    (a_q[CHUNK-1:0]),
    .b_i    (b_q[CHUNK-1:0]),
    .c_i    (carry_q),
    .sum_o  (sum),
    .cout_o (co),
    .cmsb_o (cm)
  );

  // new sum chunk enters at the top, older chunks move down
  assign acc_d = WIDTH'({sum, acc_q} >> CHUNK);
  assign ovf_d = cm ^ co;

`ifdef ADDSUB_SAT_EN
  always_comb begin
    fin_d = acc_d;
    if (ovf_d) begin
      fin_d = acc_d[WIDTH-1]
            ? {1'b0, {(WIDTH-1){1'b1}}}
            : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign fin_d = acc_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= (bus.sub == MODE_SUB)
                     ? ~bus.b : bus.b;
            carry_q <= (bus.sub == MODE_SUB)
                     ? ~bus.cin : bus.cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= co;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            res_q   <= fin_d;
            cout_q  <= co;
            ovf_q   <= ovf_d;
            zero_q  <= (fin_d == '0);
            neg_q   <= fin_d[WIDTH-1];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: CHUNK=4 and CHUNK=16 instances vs a model.
// Honours ADDSUB_SAT_EN in its expectations.
module tb_addsub_serial;

  localparam int W = 16;
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic [7:0] left;
    exp_t       out;
    exp_t       pend;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(W)) bus4 ();
  addsub_serial_if #(.WIDTH(W)) bus16 ();

  addsub_serial #(.WIDTH(W), .CHUNK(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  addsub_serial #(.WIDTH(W), .CHUNK(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  function automatic exp_t calc(logic sub, logic [W-1:0] a,
                                logic [W-1:0] b, logic cin);
    exp_t   e;
    longint ua, ub, s, u;
    ua = longint'(a);
    ub = longint'(b);
    if (!sub) begin
      u = ua + ub + longint'(cin);
      s = longint'($signed(a)) + longint'($signed(b))
        + longint'(cin);
    end else begin
      // a - b - cin in unsigned terms; no borrow <=> carry out
      u = ua - ub - longint'(cin);
      s = longint'($signed(a)) - longint'($signed(b))
        - longint'(cin);
    end
    e.res  = u[W-1:0];
    e.cout = sub ? (u >= 0) : (u > longint'(SMAX) * 2 + 1);
    e.ovf  = (s > SMAX) || (s < SMIN);
`ifdef ADDSUB_SAT_EN
    if (s > SMAX) e.res = W'(SMAX);
    if (s < SMIN) e.res = W'(SMIN);
`endif
    e.zero = (e.res == '0);
    e.neg  = e.res[W-1];
    return e;
  endfunction

  function automatic mdl_t step(mdl_t m, logic rst, logic st,
                                logic sub, logic [W-1:0] a,
                                logic [W-1:0] b, logic cin,
                                int n);
    if (rst) begin
      m.ready = 1'b1;
      m.done  = 1'b0;
      m.left  = '0;
      m.out   = '0;
    end else if (m.ready) begin
      if (st) begin
        m.ready = 1'b0;
        m.left  = 8'(n);
        m.pend  = calc(sub, a, b, cin);
      end
    end else if (m.done) begin
      m.done  = 1'b0;
      m.ready = 1'b1;
    end else begin
      m.left = m.left - 8'd1;
      if (m.left == 8'd0) begin
        m.done = 1'b1;
        m.out  = m.pend;
      end
    end
    return m;
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(string nm, logic rdy, logic dn,
                          logic [W-1:0] r, logic co,
                          logic ov, logic z, logic ng, mdl_t m);
    check({nm, ".ready"}, 32'(rdy), 32'(m.ready));
    check({nm, ".done"}, 32'(dn), 32'(m.done));
    check({nm, ".result"}, 32'(r), 32'(m.out.res));
    check({nm, ".cout"}, 32'(co), 32'(m.out.cout));
    check({nm, ".ovf"}, 32'(ov), 32'(m.out.ovf));
    check({nm, ".zero"}, 32'(z), 32'(m.out.zero));
    check({nm, ".neg"}, 32'(ng), 32'(m.out.neg));
  endtask

  mdl_t m4 = '0;
  mdl_t m16 = '0;

  always @(posedge clk) begin
    m4  = step(m4, reset, bus4.start, bus4.sub, bus4.a,
               bus4.b, bus4.cin, 4);
    m16 = step(m16, reset, bus16.start, bus16.sub, bus16.a,
               bus16.b, bus16.cin, 1);
    #1;
    chk_inst("d4", bus4.ready, bus4.done, bus4.result,
             bus4.cout, bus4.overflow, bus4.zero,
             bus4.negative, m4);
    chk_inst("d16", bus16.ready, bus16.done, bus16.result,
             bus16.cout, bus16.overflow, bus16.zero,
             bus16.negative, m16);
  end

  task automatic do_op(input bit i16, input logic sub,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic cin, output int lat);
    int k;
    k = 0;
    while (!(i16 ? bus16.ready : bus4.ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      ncmp++;
      nfail++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    if (i16) begin
      bus16.start = 1'b1; bus16.sub = sub;
      bus16.a = a; bus16.b = b; bus16.cin = cin;
    end else begin
      bus4.start = 1'b1; bus4.sub = sub;
      bus4.a = a; bus4.b = b; bus4.cin = cin;
    end
    @(negedge clk);
    bus16.start = 1'b0;
    bus4.start  = 1'b0;
    lat = 1;
    while (!(i16 ? bus16.done : bus4.done) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      ncmp++;
      nfail++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
  endtask

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] E_P_OVF = 16'h7FFF;
  localparam logic         E_P_NEG = 1'b0;
  localparam logic [W-1:0] E_N_OVF = 16'h8000;
`else
  localparam logic [W-1:0] E_P_OVF = 16'h8000;
  localparam logic         E_P_NEG = 1'b1;
  localparam logic [W-1:0] E_N_OVF = 16'h7FFF;
`endif

  initial begin
    int   lat;
    bit   saw;
    exp_t e;
    bus4.start = 1'b0; bus4.sub = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus16.start = 1'b0; bus16.sub = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus4.ready), 32'd1);
    check("rst_result", 32'(bus4.result), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    reset = 1'b0;

    e = calc(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    check("m_add_res", 32'(e.res), 32'h2233);
    e = calc(1'b1, 16'h0005, 16'h0005, 1'b0);
    check("m_sub_cout", 32'(e.cout), 32'd1);
    e = calc(1'b1, 16'h0000, 16'h0001, 1'b0);
    check("m_sub_res", 32'(e.res), 32'hFFFF);

    do_op(1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, lat);
    check("lat4", 32'(lat), 32'd5);
    check("add_res", 32'(bus4.result), 32'h2233);
    check("add_cout", 32'(bus4.cout), 32'd0);
    check("add_ovf", 32'(bus4.overflow), 32'd0);

    do_op(1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
    check("povf_res", 32'(bus4.result), 32'(E_P_OVF));
    check("povf_ovf", 32'(bus4.overflow), 32'd1);
    check("povf_neg", 32'(bus4.negative), 32'(E_P_NEG));

    do_op(1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0, lat);
    check("sub0_res", 32'(bus4.result), 32'h0000);
    check("sub0_zero", 32'(bus4.zero), 32'd1);
    check("sub0_cout", 32'(bus4.cout), 32'd1);
    check("sub0_ovf", 32'(bus4.overflow), 32'd0);

    do_op(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, lat);
    check("subm1_res", 32'(bus4.result), 32'hFFFF);
    check("subm1_cout", 32'(bus4.cout), 32'd0);
    check("subm1_neg", 32'(bus4.negative), 32'd1);
    check("subm1_ovf", 32'(bus4.overflow), 32'd0);

    do_op(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, lat);
    check("novf_res", 32'(bus4.result), 32'(E_N_OVF));
    check("novf_ovf", 32'(bus4.overflow), 32'd1);

    do_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, lat);
    check("lat16", 32'(lat), 32'd2);
    check("c16_res", 32'(bus16.result), 32'h0000);
    check("c16_cout", 32'(bus16.cout), 32'd1);
    check("c16_zero", 32'(bus16.zero), 32'd1);

    // start during RUN must be ignored
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = 1'b0;
    bus4.a = 16'h1234; bus4.b = 16'h0FFF; bus4.cin = 1'b0;
    @(negedge clk);
    bus4.a = 16'hFFFF; bus4.b = 16'hFFFF; bus4.sub = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0;
    while (!bus4.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_res", 32'(bus4.result), 32'h2233);
    @(negedge clk);

    // reset two cycles into RUN
    bus4.start = 1'b1; bus4.sub = 1'b0;
    bus4.a = 16'h0101; bus4.b = 16'h0202; bus4.cin = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 32'(bus4.ready), 32'd1);
    check("mid_rst_res", 32'(bus4.result), 32'd0);
    saw = 1'b0;
    repeat (8) begin
      if (bus4.done) saw = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_nodone", 32'(saw), 32'd0);

    // reset and start together: reset wins
    reset = 1'b1;
    bus4.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus4.start = 1'b0;
    @(negedge clk);
    check("rst_start_ready", 32'(bus4.ready), 32'd1);

    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      bus4.start  = ($urandom_range(0, 3) != 0);
      bus4.sub    = 1'($urandom);
      bus4.a      = 16'($urandom);
      bus4.b      = 16'($urandom);
      bus4.cin    = 1'($urandom);
      bus16.start = ($urandom_range(0, 3) != 0);
      bus16.sub   = 1'($urandom);
      bus16.a     = 16'($urandom);
      bus16.b     = 16'($urandom);
      bus16.cin   = 1'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    bus4.start  = 1'b0;
    bus16.start = 1'b0;
    reset = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
